pulse_sample_framer: RTL and testbench

PULSE_SAMPLE_FRAMER -- requirements
Module: pulse_sample_framer

---
 rtl/pulse_sample_framer_if.sv | 20 ++
 rtl/pulse_sample_framer.sv | 175 +++++++++++++++++
 tb/tb_pulse_sample_framer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_sample_framer_if.sv
// Byte-stream and sample-strobe signals shared by the framer and its neighbours.
// master = the framer itself, slave = the upstream counter / downstream transmitter side.
interface pulse_sample_framer_if;
    logic [31:0] iPulseCount;
    logic        iDataUpdate;
    logic [7:0]  oData;
    logic        oValid;
    logic        iReady;
    logic        oSof;
    logic        oEof;

    modport master (
        input  iPulseCount, iDataUpdate, iReady,
        output oData, oValid, oSof, oEof
    );
    modport slave (
        output iPulseCount, iDataUpdate, iReady,
        input  oData, oValid, oSof, oEof
    );
endinterface

// File: rtl/pulse_sample_framer.sv
// Buffers pulse-count samples in a FIFO and emits A5 5A SEQ + N big-endian words as a byte stream.
// Optional FRAMER_CHECKSUM_EN appends an XOR checksum byte (SEQ ^ all data bytes).
module pulse_sample_framer #(
    parameter int SAMPLES_PER_FRAME = 6,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    pulse_sample_framer_if.master bus,
    output logic                  oOverflow,
    output logic [15:0]           oDropCnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(SAMPLES_PER_FRAME);
    localparam logic [3:0]       LAST_WORD = 4'(SAMPLES_PER_FRAME - 1);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, SEQ, DATA
`ifdef FRAMER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_q, byte_d;
    logic [3:0]        word_q, word_d;
    logic [7:0]        seq_q, seq_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              frame_rdy_q;
    logic              ovf_q;
    logic [15:0]       drop_cnt_q;
`ifdef FRAMER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic       xfer, pop, wr, drop, full;
    logic [7:0] data_c, head_byte;
    logic       sof_c, eof_c;

    assign full      = (level_q == FULL_LVL);
    assign xfer      = en && (state_q != IDLE) && bus.iReady;
    assign wr        = en && bus.iDataUpdate && (!full || pop);
    assign drop      = en && bus.iDataUpdate && full && !pop;
    // byte_q 0 selects the MSB of the head word
    assign head_byte = 8'(mem_q[rd_ptr_q] >> {~byte_q, 3'b000});

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        word_d  = word_q;
        seq_d   = seq_q;
        pop     = 1'b0;
        data_c  = 8'h00;
        sof_c   = 1'b0;
        eof_c   = 1'b0;
`ifdef FRAMER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: if (frame_rdy_q && level_q >= FRAME_LVL) state_d = HDR0;
            HDR0: begin
                data_c = 8'hA5;
                sof_c  = 1'b1;
                if (xfer) state_d = HDR1;
            end
            HDR1: begin
                data_c = 8'h5A;
                if (xfer) state_d = SEQ;
            end
            SEQ: begin
                data_c = seq_q;
                if (xfer) begin
                    state_d = DATA;
                    byte_d  = 2'd0;
                    word_d  = 4'd0;
`ifdef FRAMER_CHECKSUM_EN
                    csum_d  = seq_q;
`endif
                end
            end
            DATA: begin
                data_c = head_byte;
`ifndef FRAMER_CHECKSUM_EN
                eof_c  = (byte_q == 2'd3) && (word_q == LAST_WORD);
`endif
                if (xfer) begin
                    byte_d = byte_q + 2'd1;
`ifdef FRAMER_CHECKSUM_EN
                    csum_d = csum_q ^ head_byte;
`endif
                    if (byte_q == 2'd3) begin
                        pop    = 1'b1;
                        word_d = word_q + 4'd1;
`ifdef FRAMER_CHECKSUM_EN
                        if (word_q == LAST_WORD) state_d = CSUM;
`else
                        if (word_q == LAST_WORD) state_d = IDLE;
`endif
                    end
                end
            end
`ifdef FRAMER_CHECKSUM_EN
            CSUM: begin
                data_c = csum_q;
                eof_c  = 1'b1;
                if (xfer) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (xfer && eof_c) seq_d = seq_q + 8'd1;
        if (!en) begin
            state_d = IDLE;
            seq_d   = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_q      <= 2'd0;
            word_q      <= 4'd0;
            seq_q       <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_rdy_q <= 1'b0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= 16'h0000;
`ifdef FRAMER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            seq_q   <= seq_d;
`ifdef FRAMER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
            if (!en) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                level_q     <= '0;
                frame_rdy_q <= 1'b0;
            end else begin
                if (wr)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                level_q <= level_q + LVL_W'(wr) - LVL_W'(pop);
                // Lags level_q by one cycle so a frame starts on the 2nd edge after the Nth write
                frame_rdy_q <= (level_q >= FRAME_LVL);
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= bus.iPulseCount;
    end

    assign bus.oValid = (state_q != IDLE);
    assign bus.oData  = data_c;
    assign bus.oSof   = sof_c;
    assign bus.oEof   = eof_c;
    assign oOverflow  = ovf_q;
    assign oDropCnt   = drop_cnt_q;
endmodule

// File: tb/tb_pulse_sample_framer.sv
// Directed bench for pulse_sample_framer: cycle table for the first frame, then
// backpressure, overflow, abort, mid-frame reset, sequence wrap (and checksum with FRAMER_CHECKSUM_EN).
module tb_pulse_sample_framer;
    localparam int N     = 6;
    localparam int DEPTH = 16;
`ifdef FRAMER_CHECKSUM_EN
    localparam int FL = 4 + 4 * N;
`else
    localparam int FL = 3 + 4 * N;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        oOverflow;
    logic [15:0] oDropCnt;

    pulse_sample_framer_if bus();

    pulse_sample_framer #(.SAMPLES_PER_FRAME(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bus      (bus),
        .oOverflow(oOverflow),
        .oDropCnt (oDropCnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] smp [N];
    logic [7:0]  exp_b [$];
    logic [7:0]  last_byte;

    typedef struct {
        logic        upd;
        logic [31:0] cnt;
        logic        rdy;
        logic        v;
        logic [7:0]  d;
        logic        sof;
        logic        eof;
    } vec_t;
    vec_t vt [FL + 9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task step();
        @(posedge clk);
        #1;
    endtask

    task push(input logic [31:0] v);
        bus.iDataUpdate = 1'b1;
        bus.iPulseCount = v;
        step();
        bus.iDataUpdate = 1'b0;
    endtask

    task push_frame();
        for (int i = 0; i < N; i++) push(smp[i]);
    endtask

    // Expected frame bytes from smp[] and the given sequence number
    task build(input logic [7:0] seq);
        logic [7:0] cs, b;
        exp_b.delete();
        exp_b.push_back(8'hA5);
        exp_b.push_back(8'h5A);
        exp_b.push_back(seq);
        cs = seq;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) begin
                b = 8'(smp[i] >> (24 - 8 * k));
                exp_b.push_back(b);
                cs = cs ^ b;
            end
`ifdef FRAMER_CHECKSUM_EN
        exp_b.push_back(cs);
`endif
    endtask

    // Consume bytes until oEof transfers or limit bytes have transferred (bounded by cycles)
    task collect(input bit toggle, input int limit, output int got, output bit saw_eof);
        logic [7:0] prev_d;
        bit         stalled;
        got = 0; saw_eof = 0; stalled = 0; prev_d = 8'h00;
        for (int cyc = 0; cyc < 400 && got < limit && !saw_eof; cyc++) begin
            bus.iReady = toggle ? (cyc % 2 == 0) : 1'b1;
            if (stalled) chk("stall_data", bus.oData, prev_d);
            if (got > 0) chk("valid_hold", bus.oValid, 1'b1);
            if (bus.oValid && bus.iReady) begin
                if (got < exp_b.size()) chk("byte", bus.oData, exp_b[got]);
                chk("sof", bus.oSof, got == 0);
                chk("eof", bus.oEof, got == exp_b.size() - 1);
                last_byte = bus.oData;
                if (bus.oEof) saw_eof = 1;
                got++;
            end
            stalled = bus.oValid && !bus.iReady;
            prev_d  = bus.oData;
            step();
        end
        bus.iReady = 1'b1;
    endtask

    initial begin
        int         got;
        bit         eof_seen;
        int         b, idx;
        logic [31:0] ov [17];

        // Cycle table: six strobes 1..6, then a full frame at iReady=1
        for (int r = 0; r < FL + 9; r++) begin
            vt[r] = '{upd: 1'b0, cnt: 32'h0, rdy: 1'b1, v: 1'b0, d: 8'h00, sof: 1'b0, eof: 1'b0};
            if (r < N) begin
                vt[r].upd = 1'b1;
                vt[r].cnt = 32'(r + 1);
            end
            if (r >= 7 && r < 7 + FL) begin
                b = r - 7;
                vt[r].v   = 1'b1;
                vt[r].sof = (b == 0);
                vt[r].eof = (b == FL - 1);
                if (b == 0)                vt[r].d = 8'hA5;
                else if (b == 1)           vt[r].d = 8'h5A;
                else if (b == 2)           vt[r].d = 8'h00;
                else if (b >= 3 + 4 * N)   vt[r].d = 8'h07;
                else begin
                    idx = b - 3;
                    vt[r].d = (idx % 4 == 3) ? 8'(idx / 4 + 1) : 8'h00;
                end
            end
        end

        rst_n = 1'b0; en = 1'b1;
        bus.iDataUpdate = 1'b1; bus.iPulseCount = 32'hDEADBEEF; bus.iReady = 1'b1;
        repeat (3) step();
        chk("rst_valid", bus.oValid, 1'b0);
        chk("rst_data", bus.oData, 8'h00);
        chk("rst_sof", bus.oSof, 1'b0);
        chk("rst_eof", bus.oEof, 1'b0);
        chk("rst_ovf", oOverflow, 1'b0);
        chk("rst_drop", oDropCnt, 16'h0);
        rst_n = 1'b1; bus.iDataUpdate = 1'b0;

        for (int r = 0; r < FL + 9; r++) begin
            bus.iDataUpdate = vt[r].upd;
            bus.iPulseCount = vt[r].cnt;
            bus.iReady      = vt[r].rdy;
            step();
            chk($sformatf("tbl%0d_valid", r), bus.oValid, vt[r].v);
            if (vt[r].v) begin
                chk($sformatf("tbl%0d_data", r), bus.oData, vt[r].d);
                chk($sformatf("tbl%0d_sof", r), bus.oSof, vt[r].sof);
                chk($sformatf("tbl%0d_eof", r), bus.oEof, vt[r].eof);
            end
        end

        // Backpressure: same samples, iReady toggling
        for (int i = 0; i < N; i++) smp[i] = 32'(i + 1);
        push_frame();
        build(8'h01);
        collect(1'b1, FL, got, eof_seen);
        chk("bp_count", got, FL);
        chk("bp_eof", eof_seen, 1'b1);

        // Overflow: 17 strobes while stalled
        bus.iReady = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ov[i] = {8'(i), 8'hC3, 8'(~i), 8'h5A};
            push(ov[i]);
        end
        chk("ovf_flag", oOverflow, 1'b1);
        chk("ovf_cnt", oDropCnt, 16'd1);
        chk("ovf_hdr_valid", bus.oValid, 1'b1);
        chk("ovf_hdr_data", bus.oData, 8'hA5);
        for (int i = 0; i < N; i++) smp[i] = ov[i];
        build(8'h02);
        collect(1'b0, FL, got, eof_seen);
        chk("ovf_f1_count", got, FL);
        chk("gap_idle", bus.oValid, 1'b0);
        step();
        chk("gap_restart", bus.oValid, 1'b1);
        for (int i = 0; i < N; i++) smp[i] = ov[N + i];
        build(8'h03);
        collect(1'b0, FL, got, eof_seen);
        chk("ovf_f2_count", got, FL);
        repeat (3) step();
        chk("ovf_rest_idle", bus.oValid, 1'b0);
        en = 1'b0;
        repeat (2) step();
        chk("dis_valid", bus.oValid, 1'b0);
        chk("dis_ovf_kept", oOverflow, 1'b1);
        chk("dis_cnt_kept", oDropCnt, 16'd1);
        en = 1'b1;

        // Abort after 10 bytes, then a fresh frame restarts at SEQ 0
        for (int i = 0; i < N; i++) smp[i] = 32'h0102_0300 + 32'(i);
        push_frame();
        build(8'h00);
        collect(1'b0, 10, got, eof_seen);
        chk("abort_count", got, 10);
        chk("abort_no_eof", eof_seen, 1'b0);
        en = 1'b0;
        step();
        chk("abort_valid", bus.oValid, 1'b0);
        en = 1'b1;
        for (int i = 0; i < N; i++) smp[i] = 32'hCAFE_0000 + 32'(i * 17);
        push_frame();
        build(8'h00);
        collect(1'b0, FL, got, eof_seen);
        chk("reen_count", got, FL);
        chk("reen_eof", eof_seen, 1'b1);

        // Mid-frame reset discards the frame and the queued samples
        push_frame();
        build(8'h01);
        collect(1'b0, 5, got, eof_seen);
        rst_n = 1'b0;
        step();
        chk("mrst_valid", bus.oValid, 1'b0);
        chk("mrst_ovf", oOverflow, 1'b0);
        chk("mrst_cnt", oDropCnt, 16'h0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("mrst_empty", bus.oValid, 1'b0);

        // Sequence wrap over 257 frames
        for (int f = 0; f < 257; f++) begin
            for (int i = 0; i < N; i++) smp[i] = {8'(f), 8'(i), 8'hF0, 8'(f + i)};
            push_frame();
            build(8'(f));
            collect(1'b0, FL, got, eof_seen);
            chk($sformatf("wrap%0d_count", f), got, FL);
        end
        chk("wrap_ovf", oOverflow, 1'b0);

`ifdef FRAMER_CHECKSUM_EN
        en = 1'b0;
        step();
        en = 1'b1;
        for (int i = 0; i < N; i++) smp[i] = 32'h1122_3344;
        push_frame();
        build(8'h00);
        collect(1'b0, FL, got, eof_seen);
        chk("csum_count", got, FL);
        chk("csum_byte", last_byte, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
